// File: rtl/alu_mul_pkg.sv
// alu_mul_pkg: ALU function codes, flag bit indices and sequencer state encoding
package alu_mul_pkg;
  localparam logic [3:0] FS_ADD = 4'h4;
  localparam logic [3:0] FS_IDLE = 4'h0;
  localparam int Z = 3;
  localparam int C = 2;
  localparam int N = 1;
  localparam int O = 0;
  typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, ADDW, SHIFT, DONE} state_t;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add multiplier using the external ALU for every add; start/mul_a/mul_b in, busy/done/product/prod_zero out, alu_a/alu_b/alu_fun_sel to ALU, alu_out/alu_zcno from ALU
module alu_mul_sequencer
  import alu_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mul_a,
  input  logic [WIDTH-1:0]   mul_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               prod_zero,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_fun_sel,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic [3:0]         alu_zcno
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] p_hi, p_lo, mcand;
  logic carry;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] shifted;
  assign shifted = {carry, p_hi, p_lo[WIDTH-1:1]};
  assign alu_a = p_hi;
  assign alu_b = mcand;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      prod_zero <= 1'b1;
      alu_fun_sel <= FS_IDLE;
      p_hi <= '0;
      p_lo <= '0;
      mcand <= '0;
      carry <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          busy <= 1'b1;
          p_lo <= mul_b;
          mcand <= mul_a;
        end
        LOAD: begin
          p_hi <= '0;
          cnt <= '0;
          carry <= 1'b0;
          state <= TEST;
        end
        TEST: if (p_lo[0]) begin
          alu_fun_sel <= FS_ADD;
          state <= ADD;
        end else begin
          carry <= 1'b0;
          state <= SHIFT;
        end
        ADD: state <= ADDW;
        ADDW: begin
          p_hi <= alu_out;
          carry <= alu_zcno[C];
          alu_fun_sel <= FS_IDLE;
          state <= SHIFT;
        end
        SHIFT: begin
          {p_hi, p_lo} <= shifted;
          carry <= 1'b0;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done <= 1'b1;
            product <= shifted;
            prod_zero <= shifted == '0;
          end else state <= TEST;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle 8x8 unsigned shift-and-add multiplier controller.
- Drives the existing 8-bit ALU as its initiator: it presents A, B and FunSel to the ALU and consumes OutALU and ZCNO.
- Sits beside the ALU in the datapath and exposes a Start/Done handshake to the control unit.
- It performs no addition itself; every add goes through the ALU and uses the ALU carry flag.

Parameters:
- WIDTH, 8, operand width; the product is 2*WIDTH bits.
- FS_ADD, 4'h4, ALU FunSel code for A+B, which sets C and O.
- FS_IDLE, 4'h0, ALU FunSel code driven when the ALU is not in use.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request pulse; sampled only in IDLE.
- MulA  in  8  multiplicand; captured on Start.
- MulB  in  8  multiplier; captured on Start.
- Busy  out  1  high from LOAD through DONE inclusive.
- Done  out  1  single-cycle pulse; Product is valid in that cycle.
- Product  out  16  result; held until the next Start or Reset.
- ProdZero  out  1  Product==0, updated with Product.
- AluA  out  8  ALU operand A, driven from P_hi.
- AluB  out  8  ALU operand B, driven from Mcand.
- AluFunSel  out  4  ALU function select.
- AluOut  in  8  ALU result; combinational w.r.t. AluA/AluB/AluFunSel.
- AluZCNO  in  4  ALU flags {Z,C,N,O}; registered inside the ALU on CLK.

Behaviour:
- Reset (one clock, synchronous, active-high):
  - state=IDLE.
  - Busy=0, Done=0, Product=0, ProdZero=1.
  - AluA=0, AluB=0, AluFunSel=FS_IDLE.
  - Internal P_hi, P_lo, Mcand, carry and cnt all cleared.
- Reset mid-operation aborts at once. No Done pulse is issued for the aborted operation.
- Internal registers: P_hi[7:0], P_lo[7:0], Mcand[7:0], carry[0], cnt[2:0].
- States and transitions:
  - IDLE: if Start, go to LOAD; otherwise stay.
  - LOAD: P_hi=0, P_lo=MulB, Mcand=MulA, cnt=0, carry=0. Go to TEST.
  - TEST: if P_lo[0]=1, go to ADD. Otherwise set carry=0 and go to SHIFT.
  - ADD: drive AluA=P_hi, AluB=Mcand, AluFunSel=FS_ADD. Go to ADDW.
  - ADDW: keep the same ALU drive; the ALU flags are now valid. At the end of the cycle: P_hi<=AluOut, carry<=AluZCNO[2]. Go to SHIFT.
  - SHIFT: {carry,P_hi,P_lo} logically shifted right by 1, with carry shifted into P_hi[7]; then carry=0 and cnt=cnt+1.
    - If cnt was 7 before the increment, go to DONE.
    - Otherwise go to TEST.
  - DONE: Product={P_hi,P_lo}, ProdZero updated, Done=1 for this cycle only. Go to IDLE.
- ALU drive outside ADD/ADDW: AluA=P_hi, AluB=Mcand, AluFunSel=FS_IDLE. The ALU flags are ignored in those states.
- Latency from the Start-sampled edge to Done high = 18 + 2*popcount(MulB) cycles. Minimum 18, maximum 34.
- Start while Busy is ignored, and MulA/MulB are not re-sampled.
- Start asserted in the DONE cycle is ignored. Start in the cycle after DONE (state IDLE) is accepted, so back-to-back operations are possible with a 1-cycle gap.
- Product and ProdZero change only in DONE or on Reset. The old result stays stable while a new operation runs.
- Arithmetic is unsigned; the full 16-bit product never overflows. The ALU O flag is unused.

Decomposition:
- Package alu_mul_pkg holds:
  - the FunSel constants FS_ADD and FS_IDLE;
  - the flag bit indices Z=3, C=2, N=1, O=0;
  - the state encoding IDLE, LOAD, TEST, ADD, ADDW, SHIFT, DONE (3 bits).
- Single module; no sub-module is needed.
- The bench instantiates the real alu and connects it to the Alu* ports.

Test Plan:
- MulA=8'h05, MulB=8'h02, Start pulse -> Done high 20 cycles later, Product=16'h000A, ProdZero=0; AluFunSel=4'h4 for exactly 2 cycles.
- MulA=8'hFF, MulB=8'hFF -> Done after 34 cycles, Product=16'hFE01. Exercises C=1 on every add after the first.
- MulA=8'h7F, MulB=8'h00 -> Done after 18 cycles, Product=16'h0000, ProdZero=1; AluFunSel never 4'h4.
- Run 8'h03*8'h04; assert Start with MulA=8'h11, MulB=8'h11 while Busy -> first result 16'h000C; second Start ignored, no second Done.
- Start 8'hFF*8'hFF, assert Reset 10 cycles later for 1 cycle -> Busy=0, Product=0, no Done. Then 8'h80*8'h02 -> Product=16'h0100.
- Two back-to-back ops, 8'h10*8'h10 then 8'h02*8'h81 (Start in the cycle after Done) -> Product=16'h0100, then 16'h0102.
